// File: rtl/imem_responder.sv
// Instruction-memory responder: returns the word at the PC byte address after a
// fixed access latency, holding the PC via stall_o while a fetch is outstanding.
module imem_responder #(
  parameter int DEPTH   = 256,
  parameter int IDX_W   = 8,
  parameter int LATENCY = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  input  logic [31:0]      addr_i,
  input  logic             load_en_i,
  input  logic [IDX_W-1:0] load_addr_i,
  input  logic [31:0]      load_data_i,
  output logic [31:0]      instr_o,
  output logic             valid_o,
  output logic             stall_o,
  output logic             misalign_o,
  output logic             range_err_o
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0]  LAT_M1  = 4'(LATENCY - 1);
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] addr_p0;
  logic [31:0] mem [0:DEPTH-1];

  logic             mis_p0;
  logic             rng_p0;
  logic [IDX_W-1:0] idx_p0;

  assign mis_p0 = (addr_p0[1:0] != 2'b00);
  assign rng_p0 = (addr_p0[31:2] >= DEPTH_W);
  assign idx_p0 = addr_p0[IDX_W+1:2];

  // Faulting fetches return a NOP so the core never executes garbage.
  function automatic logic [31:0] resp_word(input logic mis, input logic rng,
                                            input logic [31:0] word);
    return (mis | rng) ? 32'h0000_0000 : word;
  endfunction

  assign stall_o = (state == WAIT) | (((state == IDLE) | (state == RESP)) & req_i);

  always_ff @(posedge clk_i) begin
    if (load_en_i && !rst_i) begin
      mem[load_addr_i] <= load_data_i;
    end
  end

  // Request accept (p0 address latch) -> latency countdown -> registered response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      instr_o     <= 32'h0000_0000;
      valid_o     <= 1'b0;
      misalign_o  <= 1'b0;
      range_err_o <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req_i) begin
            addr_p0 <= addr_i;
            cnt     <= LAT_M1;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            valid_o     <= 1'b1;
            misalign_o  <= mis_p0;
            range_err_o <= rng_p0;
            instr_o     <= resp_word(mis_p0, rng_p0, mem[idx_p0]);
            state       <= RESP;
          end
        end
        RESP: begin
          if (req_i) begin
            addr_p0 <= addr_i;
            cnt     <= LAT_M1;
            state   <= WAIT;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: a LATENCY=2 instance for most steps and a
// LATENCY=1 instance for the short-latency case, sharing clock, reset and load port.
module tb_imem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_en;
  logic [7:0]  load_addr;
  logic [31:0] load_data;

  logic        req0, req1;
  logic [31:0] addr0, addr1;
  logic [31:0] instr0, instr1;
  logic        valid0, valid1, stall0, stall1, mis0, mis1, rng0, rng1;

  int total = 0;
  int bad   = 0;
  logic [31:0] words [0:7];

  always #5 clk = ~clk;

  imem_responder #(.DEPTH(256), .IDX_W(8), .LATENCY(2)) dut0 (
    .clk_i(clk), .rst_i(rst), .req_i(req0), .addr_i(addr0),
    .load_en_i(load_en), .load_addr_i(load_addr), .load_data_i(load_data),
    .instr_o(instr0), .valid_o(valid0), .stall_o(stall0),
    .misalign_o(mis0), .range_err_o(rng0)
  );

  imem_responder #(.DEPTH(256), .IDX_W(8), .LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req1), .addr_i(addr1),
    .load_en_i(load_en), .load_addr_i(load_addr), .load_data_i(load_data),
    .instr_o(instr1), .valid_o(valid1), .stall_o(stall1),
    .misalign_o(mis1), .range_err_o(rng1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One isolated LATENCY=2 fetch on dut0, starting and ending in IDLE.
  task automatic fetch0(input string tag, input logic [31:0] a, input logic [31:0] exp_instr,
                        input logic exp_mis, input logic exp_rng);
    req0 = 1'b1;
    addr0 = a;
    next_cycle();
    req0 = 1'b0;
    addr0 = 32'h0;
    next_cycle();
    next_cycle();
    #1;
    check({tag, " valid"}, 32'(valid0), 32'd1);
    check({tag, " instr"}, instr0, exp_instr);
    check({tag, " misalign"}, 32'(mis0), 32'(exp_mis));
    check({tag, " range"}, 32'(rng0), 32'(exp_rng));
    next_cycle();
    check({tag, " valid drop"}, 32'(valid0), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    for (int i = 0; i < 8; i++) words[i] = 32'h1000_0000 + 32'(i);
    words[3] = 32'h8C01_0004;
    words[5] = 32'h1111_0005;

    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    #1;
    check("rst valid", 32'(valid0), 32'd0);
    check("rst instr", instr0, 32'd0);
    check("rst misalign", 32'(mis0), 32'd0);
    check("rst range", 32'(rng0), 32'd0);
    check("rst stall", 32'(stall0), 32'd0);
    check("rst valid1", 32'(valid1), 32'd0);

    for (int i = 0; i < 8; i++) begin
      load_en = 1'b1;
      load_addr = 8'(i);
      load_data = words[i];
      next_cycle();
    end
    load_en = 1'b0;

    // Basic fetch of mem[3], latency 2, stall through request and WAIT.
    req0 = 1'b1; addr0 = 32'h0000_000C;
    #1;
    check("t2 stall req", 32'(stall0), 32'd1);
    next_cycle();
    req0 = 1'b0;
    #1;
    check("t2 stall w1", 32'(stall0), 32'd1);
    check("t2 valid w1", 32'(valid0), 32'd0);
    next_cycle();
    #1;
    check("t2 stall w2", 32'(stall0), 32'd1);
    check("t2 valid w2", 32'(valid0), 32'd0);
    next_cycle();
    #1;
    check("t2 valid", 32'(valid0), 32'd1);
    check("t2 instr", instr0, 32'h8C01_0004);
    check("t2 stall resp", 32'(stall0), 32'd0);
    next_cycle();
    #1;
    check("t2 valid drop", 32'(valid0), 32'd0);
    check("t2 instr hold", instr0, 32'h8C01_0004);

    // Back-to-back: one word per 3 cycles, addr_i ignored during WAIT.
    for (int k = 0; k < 3; k++) begin
      req0 = 1'b1;
      addr0 = 32'(k * 4);
      #1;
      check("t3 stall", 32'(stall0), 32'd1);
      next_cycle();
      addr0 = 32'hFFFF_FFF0;
      #1;
      check("t3 wait1", 32'(valid0), 32'd0);
      next_cycle();
      #1;
      check("t3 wait2", 32'(valid0), 32'd0);
      next_cycle();
      #1;
      check("t3 valid", 32'(valid0), 32'd1);
      check("t3 instr", instr0, words[k]);
    end
    req0 = 1'b0;
    #1;
    check("t3 stall release", 32'(stall0), 32'd0);
    next_cycle();
    check("t3 idle", 32'(valid0), 32'd0);

    // Error responses.
    fetch0("t4 misalign", 32'h0000_0006, 32'h0, 1'b1, 1'b0);
    fetch0("t4 range", 32'h0000_0400, 32'h0, 1'b0, 1'b1);
    check("t4 range hold", 32'(rng0), 32'd1);
    check("t4 instr hold", instr0, 32'h0);
    fetch0("t4 both", 32'h0000_0402, 32'h0, 1'b1, 1'b1);
    fetch0("t4 clean", 32'h0000_001C, words[7], 1'b0, 1'b0);

    // Load on the WAIT->RESP edge returns the old word.
    req0 = 1'b1; addr0 = 32'h0000_0014;
    next_cycle();
    req0 = 1'b0;
    next_cycle();
    load_en = 1'b1; load_addr = 8'd5; load_data = 32'hDEAD_BEEF;
    next_cycle();
    load_en = 1'b0;
    #1;
    check("t5 valid", 32'(valid0), 32'd1);
    check("t5 old word", instr0, 32'h1111_0005);
    next_cycle();
    fetch0("t5 refetch", 32'h0000_0014, 32'hDEAD_BEEF, 1'b0, 1'b0);

    // Reset in the middle of WAIT aborts the fetch and clears outputs.
    req0 = 1'b1; addr0 = 32'h0000_000C;
    next_cycle();
    req0 = 1'b0;
    rst = 1'b1;
    #1;
    check("t1 stall wait", 32'(stall0), 32'd1);
    next_cycle();
    check("t1 valid r1", 32'(valid0), 32'd0);
    check("t1 instr r1", instr0, 32'd0);
    next_cycle();
    rst = 1'b0;
    #1;
    check("t1 valid r2", 32'(valid0), 32'd0);
    check("t1 stall r2", 32'(stall0), 32'd0);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      check("t1 no pulse", 32'(valid0), 32'd0);
    end
    fetch0("t1 mem kept", 32'h0000_000C, 32'h8C01_0004, 1'b0, 1'b0);

    // LATENCY=1 instance.
    req1 = 1'b1; addr1 = 32'h0000_0004;
    #1;
    check("t6 stall req", 32'(stall1), 32'd1);
    next_cycle();
    req1 = 1'b0;
    #1;
    check("t6 stall wait", 32'(stall1), 32'd1);
    check("t6 valid wait", 32'(valid1), 32'd0);
    next_cycle();
    #1;
    check("t6 valid", 32'(valid1), 32'd1);
    check("t6 instr", instr1, words[1]);
    check("t6 stall resp", 32'(stall1), 32'd0);
    next_cycle();
    check("t6 valid drop", 32'(valid1), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
